// File: rtl/audio_vol_arbiter.sv
// Round-robin arbiter for the audio encoder's vol input. Grants change only at
// encoder word boundaries, tracked by a free-running bit counter.
module audio_vol_arbiter #(
  parameter int N_REQ     = 4,
  parameter int VOL_WIDTH = 6,
  parameter int WORD_BITS = 8
) (
  input  logic                       clk_audio_bit,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*VOL_WIDTH-1:0] vol_in,
  input  logic                       mute,
  output logic [VOL_WIDTH-1:0]       vol,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   active_id,
  output logic                       word_start,
  output logic                       channel
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WORD_BITS);

  logic [CNT_W-1:0]     bit_cnt;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      ptr_next;
  logic [ID_W:0]        idx;
  logic                 win_found;
  logic                 boundary;
  logic [VOL_WIDTH-1:0] vol_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign vol_arr[k] = vol_in[k*VOL_WIDTH +: VOL_WIDTH];
  end

  assign boundary   = (bit_cnt == CNT_W'(WORD_BITS - 1));
  assign word_start = (bit_cnt == '0);

  // Cyclic search upward from ptr; the extra idx bit lets ptr+i exceed N_REQ before folding.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!win_found && req[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  assign ptr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk_audio_bit) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      bit_cnt   <= '0;
      ptr       <= '0;
      vol       <= '0;
      gnt       <= '0;
      active_id <= '0;
      channel   <= 1'b0;
    end else begin
      gnt <= '0;
      if (boundary) begin
        bit_cnt <= '0;
        channel <= ~channel;
        // Mute wins over requests and leaves them pending with ptr untouched.
        if (mute) begin
          vol <= '0;
        end else if (win_found) begin
          vol       <= vol_arr[win_id];
          active_id <= win_id;
          gnt       <= N_REQ'(1) << win_id;
          ptr       <= ptr_next;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_vol_arbiter.sv
// Scoreboard bench for audio_vol_arbiter: a word-level model pushes the expected
// result of every boundary, and a monitor pops it at each DUT word start.
module tb_audio_vol_arbiter;

  localparam int N_REQ     = 4;
  localparam int VOL_WIDTH = 6;
  localparam int WORD_BITS = 8;

  typedef struct packed {
    logic [VOL_WIDTH-1:0] vol;
    logic [N_REQ-1:0]     gnt;
    logic [1:0]           id;
  } word_t;

  logic                       clk_audio_bit = 1'b0;
  logic                       reset = 1'b1;
  logic [N_REQ-1:0]           req = '0;
  logic [N_REQ*VOL_WIDTH-1:0] vol_in = '0;
  logic                       mute = 1'b0;
  logic [VOL_WIDTH-1:0]       vol;
  logic [N_REQ-1:0]           gnt;
  logic [1:0]                 active_id;
  logic                       word_start;
  logic                       channel;

  int total = 0;
  int bad   = 0;

  audio_vol_arbiter #(.N_REQ(N_REQ), .VOL_WIDTH(VOL_WIDTH), .WORD_BITS(WORD_BITS)) dut (
    .clk_audio_bit(clk_audio_bit),
    .reset        (reset),
    .req          (req),
    .vol_in       (vol_in),
    .mute         (mute),
    .vol          (vol),
    .gnt          (gnt),
    .active_id    (active_id),
    .word_start   (word_start),
    .channel      (channel)
  );

  always #5 clk_audio_bit = ~clk_audio_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference model, stepped once per rising edge from the bench's own inputs.
  word_t exp_q[$];
  int    m_cnt = 0, m_ptr = 0, m_id = 0, m_win = 0;
  int    m_vol = 0;
  bit    m_ch = 0, m_in_reset = 1, m_gnt_evt = 0;

  task automatic model_step();
    word_t rec;
    m_gnt_evt = 0;
    if (reset) begin
      m_cnt = 0; m_ptr = 0; m_ch = 0; m_vol = 0; m_id = 0;
      m_in_reset = 1;
      exp_q.delete();
    end else begin
      m_in_reset = 0;
      if (m_cnt == WORD_BITS - 1) begin
        m_cnt = 0;
        m_ch  = !m_ch;
        if (mute) begin
          m_vol = 0;
        end else begin
          for (int k = 0; k < N_REQ; k++) begin
            int w;
            w = (m_ptr + k) % N_REQ;
            if (req[w] && !m_gnt_evt) begin
              m_gnt_evt = 1;
              m_win     = w;
            end
          end
          if (m_gnt_evt) begin
            m_vol = int'(vol_in[m_win*VOL_WIDTH +: VOL_WIDTH]);
            m_id  = m_win;
            m_ptr = (m_win + 1) % N_REQ;
          end
        end
        rec.vol = m_vol[VOL_WIDTH-1:0];
        rec.gnt = m_gnt_evt ? N_REQ'(1 << m_win) : '0;
        rec.id  = m_id[1:0];
        exp_q.push_back(rec);
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_audio_bit);
    model_step();
  end

  // Monitor: pops at every DUT word start, otherwise checks that the word is held.
  initial begin
    word_t r;
    logic [VOL_WIDTH-1:0] h_vol = '0;
    logic [1:0]           h_id  = '0;
    forever begin
      @(negedge clk_audio_bit);
      if (m_in_reset) begin
        check("rst_vol", vol, 0);
        check("rst_gnt", gnt, 0);
        check("rst_id", active_id, 0);
        check("rst_word_start", word_start, 1);
        check("rst_channel", channel, 0);
        h_vol = '0;
        h_id  = '0;
      end else begin
        check("word_start", word_start, m_cnt == 0);
        check("channel", channel, m_ch);
        if (word_start) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL q_underflow: word start with no expected word (t=%0t)", $time);
          end else begin
            r = exp_q.pop_front();
            check("word_vol", vol, r.vol);
            check("word_gnt", gnt, r.gnt);
            check("word_id", active_id, r.id);
            h_vol = r.vol;
            h_id  = r.id;
          end
        end else begin
          check("hold_vol", vol, h_vol);
          check("hold_gnt", gnt, 0);
          check("hold_id", active_id, h_id);
        end
      end
    end
  end

  bit auto_drop = 1;

  // Inputs change 2 time units after the edge; a granted requester drops its req if auto_drop.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_audio_bit);
      #2;
      if (auto_drop && m_gnt_evt) req[m_win] = 1'b0;
    end
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2*WORD_BITS && m_cnt != v; i++) tick();
    check("wait_cnt", m_cnt, v);
  endtask

  task automatic set_vol(input int k, input logic [VOL_WIDTH-1:0] v);
    vol_in[k*VOL_WIDTH +: VOL_WIDTH] = v;
  endtask

  initial begin
    // Reset at start, then again mid-word for 3 cycles.
    tick(3);
    reset = 1'b0;
    tick(13);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2 * WORD_BITS);

    // Single requester.
    set_vol(1, 6'h3F);
    req = 4'b0010;
    tick(2 * WORD_BITS);

    // Round-robin with all requesters held.
    auto_drop = 0;
    vol_in = {6'h2A, 6'h15, 6'h00, 6'h3F};
    wait_cnt(1);
    req = 4'b1111;
    tick(5 * WORD_BITS);

    // Mid-word change of requester 0's sample.
    wait_cnt(3);
    set_vol(0, 6'h11);
    tick(2 * WORD_BITS);
    req = 4'b0000;
    auto_drop = 1;
    tick(WORD_BITS);

    // Mute across a boundary with requester 2 pending, then release.
    req  = 4'b0100;
    mute = 1'b1;
    wait_cnt(0);
    mute = 1'b0;
    tick(2 * WORD_BITS);

    // Idle hold after a grant to 6'h15.
    set_vol(2, 6'h15);
    req = 4'b0100;
    tick(4 * WORD_BITS);

    // Reset coinciding with a boundary.
    req = 4'b1011;
    wait_cnt(WORD_BITS - 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2 * WORD_BITS);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = req | N_REQ'($urandom);
      if ($urandom_range(0, 5) == 0) vol_in = (N_REQ*VOL_WIDTH)'($urandom);
      mute = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) auto_drop = !auto_drop;
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    mute  = 1'b0;
    req   = '0;
    tick(3 * WORD_BITS);
    check("q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
